// File: rtl/alt_vipvfr130_pkg.sv
// Shared types and constants for the video packet decoder.
// Packet type codes, FSM states and the control-packet nibble count live here.
package alt_vipvfr130_pkg;

    localparam logic [3:0] PKT_VIDEO    = 4'h0;
    localparam logic [3:0] PKT_CTRL     = 4'hF;
    localparam logic [3:0] NIBBLE_COUNT = 4'd9;

    typedef logic [15:0] geom_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CTRL    = 2'd1,
        ST_VIDEO   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

endpackage

// File: rtl/alt_vipvfr130_ctrl_nibble_unpacker.sv
// Collects the nine control-packet nibbles (low 4 bits of each symbol) into a shift register.
// Outputs show the state including the beat being shifted this cycle, so the top can commit on EOP.
module alt_vipvfr130_ctrl_nibble_unpacker
    import alt_vipvfr130_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        shift,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data,
    output geom_t                                       width_next,
    output geom_t                                       height_next,
    output logic [3:0]                                  interlaced_next,
    output logic                                        complete_next
);

    localparam int SR_W = 36;

    logic [SR_W-1:0] sr, sr_next;
    logic [3:0]      cnt, cnt_next;
    logic            unused_data;

    assign unused_data = ^data;

    // Nibbles past the ninth are ignored; the counter saturates.
    always_comb begin
        sr_next  = sr;
        cnt_next = cnt;
        if (start) begin
            sr_next  = '0;
            cnt_next = '0;
        end else if (shift) begin
            for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
                if (cnt_next < NIBBLE_COUNT) begin
                    sr_next  = {sr_next[SR_W-5:0], data[i*BITS_PER_SYMBOL +: 4]};
                    cnt_next = cnt_next + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_next;
            cnt <= cnt_next;
        end
    end

    assign width_next      = sr_next[35:20];
    assign height_next     = sr_next[19:4];
    assign interlaced_next = sr_next[3:0];
    assign complete_next   = (cnt_next == NIBBLE_COUNT);

endmodule

// File: rtl/alt_vipvfr130_video_packet_decoder.sv
// Avalon-ST video sink: decodes control packets into frame geometry and forwards video
// pixels with x/y position and line/frame flags, flagging short and long frames.
module alt_vipvfr130_video_packet_decoder
    import alt_vipvfr130_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int DEFAULT_WIDTH    = 1920,
    parameter int DEFAULT_HEIGHT   = 1080,
    parameter int MAX_WIDTH        = 1920,
    parameter int MAX_HEIGHT       = 1080
) (
    input  logic                                        clk,
    input  logic                                        rst,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        dout_sof,
    output logic                                        dout_eof,
    output logic                                        dout_sol,
    output logic                                        dout_eol,
    output logic [15:0]                                 dout_x,
    output logic [15:0]                                 dout_y,
    output logic [15:0]                                 width,
    output logic [15:0]                                 height,
    output logic [3:0]                                  interlaced,
    output logic                                        status_short,
    output logic                                        status_long,
    input  logic                                        status_clear
);

    localparam geom_t MAX_W = geom_t'(MAX_WIDTH);
    localparam geom_t MAX_H = geom_t'(MAX_HEIGHT);

    state_t     state, state_next;
    geom_t      w_m1, h_m1, x, y;
    logic       accept, at_eol, at_eof;
    logic       start_ctrl, shift_ctrl, geom_ok;
    logic       fwd, snap, commit, set_short, set_long, force_eof;
    logic [3:0] pkt_type;
    geom_t      width_next, height_next;
    logic [3:0] interlaced_next;
    logic       complete_next;

    // A pending pixel always drains before anything else is accepted.
    assign din_ready = !dout_valid || dout_ready;
    assign accept    = din_valid && din_ready;
    assign pkt_type  = din_data[3:0];
    assign at_eol    = (x == w_m1);
    assign at_eof    = at_eol && (y == h_m1);

    assign start_ctrl = accept && din_sop && !din_eop && (pkt_type == PKT_CTRL);
    assign shift_ctrl = accept && !din_sop && (state == ST_CTRL);

    alt_vipvfr130_ctrl_nibble_unpacker #(
        .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
        .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
    ) u_unpacker (
        .clk            (clk),
        .rst            (rst),
        .start          (start_ctrl),
        .shift          (shift_ctrl),
        .data           (din_data),
        .width_next     (width_next),
        .height_next    (height_next),
        .interlaced_next(interlaced_next),
        .complete_next  (complete_next)
    );

    assign geom_ok = complete_next
                  && (width_next != '0)  && (width_next <= MAX_W)
                  && (height_next != '0) && (height_next <= MAX_H);

    always_comb begin
        state_next = state;
        fwd        = 1'b0;
        snap       = 1'b0;
        commit     = 1'b0;
        set_short  = 1'b0;
        set_long   = 1'b0;
        force_eof  = 1'b0;
        if (accept) begin
            if (din_sop) begin
                // A new header aborts whatever packet was in progress.
                set_short = (state == ST_VIDEO);
                if (din_eop) begin
                    state_next = ST_IDLE;
                end else if (pkt_type == PKT_VIDEO) begin
                    state_next = ST_VIDEO;
                    snap       = 1'b1;
                end else if (pkt_type == PKT_CTRL) begin
                    state_next = ST_CTRL;
                end else begin
                    state_next = ST_DISCARD;
                end
            end else begin
                case (state)
                    ST_CTRL: begin
                        if (din_eop) begin
                            state_next = ST_IDLE;
                            commit     = geom_ok;
                        end
                    end
                    ST_VIDEO: begin
                        fwd = 1'b1;
                        if (din_eop) begin
                            state_next = ST_IDLE;
                            set_short  = !at_eof;
                            force_eof  = !at_eof;
                        end else if (at_eof) begin
                            state_next = ST_DISCARD;
                            set_long   = 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (din_eop) state_next = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            w_m1         <= geom_t'(DEFAULT_WIDTH - 1);
            h_m1         <= geom_t'(DEFAULT_HEIGHT - 1);
            x            <= '0;
            y            <= '0;
            dout_valid   <= 1'b0;
            dout_data    <= '0;
            dout_sof     <= 1'b0;
            dout_eof     <= 1'b0;
            dout_sol     <= 1'b0;
            dout_eol     <= 1'b0;
            dout_x       <= '0;
            dout_y       <= '0;
            width        <= geom_t'(DEFAULT_WIDTH);
            height       <= geom_t'(DEFAULT_HEIGHT);
            interlaced   <= '0;
            status_short <= 1'b0;
            status_long  <= 1'b0;
        end else begin
            state <= state_next;

            // Geometry is frozen per frame so a control packet cannot disturb it mid-frame.
            if (snap) begin
                w_m1 <= width - 16'd1;
                h_m1 <= height - 16'd1;
                x    <= '0;
                y    <= '0;
            end else if (fwd) begin
                if (at_eol) begin
                    x <= '0;
                    y <= y + 16'd1;
                end else begin
                    x <= x + 16'd1;
                end
            end

            if (fwd) begin
                dout_valid <= 1'b1;
                dout_data  <= din_data;
                dout_x     <= x;
                dout_y     <= y;
                dout_sof   <= (x == '0) && (y == '0);
                dout_sol   <= (x == '0);
                dout_eol   <= at_eol;
                dout_eof   <= at_eof || force_eof;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (commit) begin
                width      <= width_next;
                height     <= height_next;
                interlaced <= interlaced_next;
            end

            status_short <= set_short || (status_short && !status_clear);
            status_long  <= set_long  || (status_long  && !status_clear);
        end
    end

endmodule

// File: tb/tb_alt_vipvfr130_video_packet_decoder.sv
// Self-checking bench: scenario table, hand-written corner sequences and randomized packets
// compared against a frame-level model of the decoder.
module tb_alt_vipvfr130_video_packet_decoder;

    localparam int BPS = 8;
    localparam int SPB = 3;
    localparam int DW  = BPS * SPB;

    logic          clk = 1'b0, rst = 1'b0;
    logic          din_ready, din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          dout_ready = 1'b1, dout_valid;
    logic [DW-1:0] dout_data;
    logic          dout_sof, dout_eof, dout_sol, dout_eol;
    logic [15:0]   dout_x, dout_y, width, height;
    logic [3:0]    interlaced;
    logic          status_short, status_long, status_clear = 1'b0;

    alt_vipvfr130_video_packet_decoder dut (
        .clk(clk), .rst(rst),
        .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
        .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
        .dout_sof(dout_sof), .dout_eof(dout_eof), .dout_sol(dout_sol), .dout_eol(dout_eol),
        .dout_x(dout_x), .dout_y(dout_y),
        .width(width), .height(height), .interlaced(interlaced),
        .status_short(status_short), .status_long(status_long), .status_clear(status_clear)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [15:0]   x;
        logic [15:0]   y;
        logic          sof, eof, sol, eol;
    } pix_t;

    typedef struct {
        int         cw, ch, cil, cb;   // control packet (cb = beats, 0 = none)
        logic [3:0] vt;
        int         vl;                // video packet type / payload beats
        int         ew, eh, eil, enpix;
        bit         eshort, elong;
    } vec_t;

    pix_t exp_q[$], act_q[$];
    int   n_checks = 0, n_fail = 0;
    int   m_w = 1920, m_h = 1080, m_il = 0;
    bit   m_short = 0, m_long = 0;
    bit   rnd_ready = 0;

    always @(posedge clk) begin
        #1;
        dout_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        pix_t p;
        if (dout_valid && dout_ready) begin
            p.data = dout_data; p.x = dout_x; p.y = dout_y;
            p.sof = dout_sof; p.eof = dout_eof; p.sol = dout_sol; p.eol = dout_eol;
            act_q.push_back(p);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [DW-1:0] d);
        int t = 0;
        din_valid = 1'b1; din_sop = sop; din_eop = eop; din_data = d;
        do begin @(negedge clk); t++; end while (!din_ready && t < 200);
        if (!din_ready) check("accept_timeout", 64'(t), 64'(0));
        @(posedge clk); #1;
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic send_ctrl(input int w, input int h, input int il, input int nb);
        logic [3:0]    nib [9];
        logic [15:0]   wv, hv;
        logic [DW-1:0] d;
        wv = 16'(w); hv = 16'(h);
        nib = '{wv[15:12], wv[11:8], wv[7:4], wv[3:0],
                hv[15:12], hv[11:8], hv[7:4], hv[3:0], 4'(il)};
        d = DW'($urandom); d[3:0] = 4'hF;
        beat(1'b1, 1'b0, d);
        for (int b = 0; b < nb; b++) begin
            d = DW'($urandom);
            for (int s = 0; s < SPB; s++)
                if (b * SPB + s < 9) d[s*BPS +: 4] = nib[b*SPB + s];
            beat(1'b0, b == nb - 1, d);
        end
        if (nb * SPB >= 9 && w > 0 && w <= 1920 && h > 0 && h <= 1080) begin
            m_w = w; m_h = h; m_il = il;
        end
        check("ctrl_width", 64'(width), 64'(m_w));
        check("ctrl_height", 64'(height), 64'(m_h));
        check("ctrl_interlaced", 64'(interlaced), 64'(m_il));
    endtask

    task automatic send_video(input logic [3:0] typ, input int n, input bit term);
        logic [DW-1:0] d;
        pix_t          p;
        int            total, x;
        d = DW'($urandom); d[3:0] = typ;
        beat(1'b1, 1'b0, d);
        total = m_w * m_h;
        if (typ == 4'h0) begin
            if (n < total) m_short = 1;
            if (n > total || (n == total && !term)) m_long = 1;
        end
        for (int i = 0; i < n; i++) begin
            d = DW'($urandom);
            if (typ == 4'h0 && i < total) begin
                x = i % m_w;
                p.data = d; p.x = 16'(x); p.y = 16'(i / m_w);
                p.sof = (i == 0); p.sol = (x == 0); p.eol = (x == m_w - 1);
                p.eof = (i == total - 1) || (term && i == n - 1 && n < total);
                exp_q.push_back(p);
            end
            beat(1'b0, term && i == n - 1, d);
        end
    endtask

    task automatic drain(input string name, output int cnt);
        int t = 0;
        while ((act_q.size() < exp_q.size() || dout_valid) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        repeat (2) begin @(posedge clk); #1; end
        cnt = act_q.size();
        check({name, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("%s_pix%0d", name, i), 64'(act_q[i]), 64'(exp_q[i]));
        act_q.delete(); exp_q.delete();
    endtask

    task automatic clear_status();
        status_clear = 1'b1;
        @(posedge clk); #1;
        status_clear = 1'b0;
        m_short = 0; m_long = 0;
        check("clear_short", 64'(status_short), 64'(0));
        check("clear_long", 64'(status_long), 64'(0));
    endtask

    initial begin
        vec_t          tbl[8];
        int            cnt;
        logic [DW-1:0] d;

        tbl[0] = '{4, 2, 3, 3, 4'h0, 8,  4, 2, 3, 8, 1'b0, 1'b0};
        tbl[1] = '{0, 0, 0, 0, 4'h0, 5,  4, 2, 3, 5, 1'b1, 1'b0};
        tbl[2] = '{0, 0, 0, 0, 4'h0, 10, 4, 2, 3, 8, 1'b0, 1'b1};
        tbl[3] = '{0, 2, 5, 3, 4'h0, 8,  4, 2, 3, 8, 1'b0, 1'b0};
        tbl[4] = '{6, 3, 1, 2, 4'h3, 6,  4, 2, 3, 0, 1'b0, 1'b0};
        tbl[5] = '{3, 3, 0, 4, 4'h0, 9,  3, 3, 0, 9, 1'b0, 1'b0};
        tbl[6] = '{1921, 2, 0, 3, 4'h0, 9, 3, 3, 0, 9, 1'b0, 1'b0};
        tbl[7] = '{1, 1, 7, 3, 4'h0, 1,  1, 1, 7, 1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_din_ready", 64'(din_ready), 64'(1));
        check("rst_dout_valid", 64'(dout_valid), 64'(0));
        check("rst_flags", 64'({dout_sof, dout_eof, dout_sol, dout_eol}), 64'(0));
        check("rst_xy", 64'({dout_x, dout_y}), 64'(0));
        check("rst_width", 64'(width), 64'(1920));
        check("rst_height", 64'(height), 64'(1080));
        check("rst_interlaced", 64'(interlaced), 64'(0));
        check("rst_status", 64'({status_short, status_long}), 64'(0));

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].cb > 0) send_ctrl(tbl[r].cw, tbl[r].ch, tbl[r].cil, tbl[r].cb);
            send_video(tbl[r].vt, tbl[r].vl, 1'b1);
            drain($sformatf("row%0d", r), cnt);
            check($sformatf("row%0d_npix", r), 64'(cnt), 64'(tbl[r].enpix));
            check($sformatf("row%0d_geom", r), 64'({width, height, interlaced}),
                  64'({16'(tbl[r].ew), 16'(tbl[r].eh), 4'(tbl[r].eil)}));
            check($sformatf("row%0d_short", r), 64'(status_short), 64'(tbl[r].eshort));
            check($sformatf("row%0d_long", r), 64'(status_long), 64'(tbl[r].elong));
            clear_status();
        end

        // A new SOP aborts an unfinished frame: short set, no forced eof.
        send_ctrl(4, 2, 0, 3);
        send_video(4'h0, 3, 1'b0);
        send_video(4'h0, 8, 1'b1);
        drain("abort", cnt);
        check("abort_short", 64'(status_short), 64'(1));
        check("abort_long", 64'(status_long), 64'(0));
        clear_status();

        // Backpressured 4x2 frame first, then randomized geometry and lengths.
        rnd_ready = 1;
        send_video(4'h0, 8, 1'b1);
        drain("stall4x2", cnt);
        check("stall4x2_status", 64'({status_short, status_long}), 64'(0));
        for (int it = 0; it < 20; it++) begin
            send_ctrl($urandom_range(0, 6), $urandom_range(1, 4), $urandom_range(0, 15),
                      $urandom_range(2, 4));
            if ($urandom_range(0, 5) == 0)
                send_video(4'h3, $urandom_range(1, 5), 1'b1);
            else
                send_video(4'h0, $urandom_range(1, m_w * m_h + 3), 1'b1);
            drain($sformatf("rnd%0d", it), cnt);
            check($sformatf("rnd%0d_short", it), 64'(status_short), 64'(m_short));
            check($sformatf("rnd%0d_long", it), 64'(status_long), 64'(m_long));
            clear_status();
        end
        rnd_ready = 0;

        // Reset mid-packet: the tail arrives without SOP and must be dropped.
        send_ctrl(4, 2, 0, 3);
        send_video(4'h0, 2, 1'b0);
        drain("rst_pre", cnt);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        m_w = 1920; m_h = 1080; m_il = 0; m_short = 0; m_long = 0;
        check("midrst_width", 64'(width), 64'(1920));
        check("midrst_status", 64'({status_short, status_long}), 64'(0));
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            beat(1'b0, i == 5, d);
        end
        drain("rst_post", cnt);
        check("rst_post_status", 64'({status_short, status_long}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
